pc_fetch_unit: RTL and testbench

- Sequential producer side of the next-PC path. Holds the architectural PC and fetches the instruction at that PC from instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched instruction to decode with a valid/ready handshake.
- On each accepted handoff, loads the next-PC value computed by the combinational next-PC logic from the delivered instruction.
- Single outstanding fetch; flags misaligned next-PC values.

---
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 tb/tb_pc_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the architectural PC, fetches one instruction at a time over
// req/gnt/rvalid and hands it to decode over valid/ready, then loads the next PC.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic [31:0] pc_out,
   output logic        addr_err,
   output logic [31:0] retire_cnt
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_inst_pc;
   logic [31:0] r_retire_cnt;
   logic        r_addr_err;
   logic        w_handoff;
   logic        w_npc_misaligned;

   assign w_handoff        = (r_state == S_VALID) && inst_ready;
   assign w_npc_misaligned = (npc_in[1:0] != 2'b00);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; ERR only leaves through reset
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH: begin
            if (imem_gnt) begin
               w_next_state = S_WAIT;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               w_next_state = S_VALID;
            end else begin
               w_next_state = S_WAIT;
            end
         end
         S_VALID: begin
            if (w_handoff && w_npc_misaligned) begin
               w_next_state = S_ERR;
            end else if (w_handoff) begin
               w_next_state = S_FETCH;
            end else begin
               w_next_state = S_VALID;
            end
         end
         S_ERR:   w_next_state = S_ERR;
         default: w_next_state = S_FETCH;
      endcase
   end

   // Datapath: capture on rvalid in WAIT, advance PC and retire count on handoff
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_inst       <= 32'h0000_0000;
         r_inst_pc    <= 32'h0000_0000;
         r_retire_cnt <= 32'h0000_0000;
         r_addr_err   <= 1'b0;
      end else begin
         if ((r_state == S_WAIT) && imem_rvalid) begin
            r_inst    <= imem_rdata;
            r_inst_pc <= r_pc;
         end
         if (w_handoff) begin
            // A misaligned target is still loaded so it can be inspected after the error
            r_pc         <= npc_in;
            r_retire_cnt <= r_retire_cnt + 32'd1;
            if (w_npc_misaligned) begin
               r_addr_err <= 1'b1;
            end
         end
      end
   end

   assign imem_req   = (r_state == S_FETCH);
   assign imem_addr  = r_pc;
   assign inst_valid = (r_state == S_VALID);
   assign inst_out   = r_inst;
   assign inst_pc    = r_inst_pc;
   assign pc_out     = r_pc;
   assign addr_err   = r_addr_err;
   assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit: the driver plays memory and decode,
// pushing expected instructions; a negedge monitor pops them on every handoff.
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] npc_in;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic [31:0] pc_out;
   logic        addr_err;
   logic [31:0] retire_cnt;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_pc;
   logic [31:0] model_retire;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .npc_in(npc_in),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_out(inst_out), .inst_pc(inst_pc), .pc_out(pc_out),
      .addr_err(addr_err), .retire_cnt(retire_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every handoff must deliver the oldest expected instruction
   always @(negedge clk) begin
      exp_t e;
      if (!rst && inst_valid && inst_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL handoff_unexpected: got inst %h pc %h expected none", inst_out, inst_pc);
         end else begin
            e = exp_q.pop_front();
            check("inst_out", inst_out, e.data);
            check("inst_pc", inst_pc, e.pc);
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0; npc_in = 32'h0;
      #3;
      check("rst_pc", pc_out, RST_PC);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_err", {31'd0, addr_err}, 32'd0);
      check("rst_retire", retire_cnt, 32'd0);
      check("rst_inst", inst_out, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      step();
      rst = 1'b0;
      exp_q.delete();
      model_pc = RST_PC;
      model_retire = 32'd0;
   endtask

   // One full fetch/handoff with gnt delay gd, rvalid delay rd and decode stall bd
   task automatic do_fetch(input int gd, input int rd, input int bd, input logic [31:0] npc);
      int          n;
      logic [31:0] d;
      n = 0;
      while (!imem_req && n < 20) begin
         step();
         n++;
      end
      check("req_latency", n, 0);
      check("imem_addr", imem_addr, model_pc);
      for (int i = 0; i < gd; i++) begin
         imem_gnt = 1'b0;
         imem_rvalid = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         inst_ready = 1'($urandom_range(0, 1));
         step();
         check("req_hold", {31'd0, imem_req}, 32'd1);
         check("addr_hold", imem_addr, model_pc);
      end
      imem_gnt = 1'b1;
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      step();
      imem_gnt = 1'b0;
      for (int i = 0; i < rd; i++) begin
         imem_rvalid = 1'b0;
         inst_ready = 1'($urandom_range(0, 1));
         step();
         check("wait_noreq", {31'd0, imem_req}, 32'd0);
         check("wait_novalid", {31'd0, inst_valid}, 32'd0);
      end
      d = $urandom;
      imem_rvalid = 1'b1;
      imem_rdata = d;
      inst_ready = 1'b0;
      exp_q.push_back('{pc: model_pc, data: d});
      step();
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      check("valid_up", {31'd0, inst_valid}, 32'd1);
      for (int i = 0; i < bd; i++) begin
         inst_ready = 1'b0;
         npc_in = $urandom;
         step();
         check("bp_valid", {31'd0, inst_valid}, 32'd1);
         check("bp_noreq", {31'd0, imem_req}, 32'd0);
         check("bp_pc", pc_out, model_pc);
         check("bp_inst", inst_out, d);
      end
      inst_ready = 1'b1;
      npc_in = npc;
      step();
      inst_ready = 1'b0;
      npc_in = $urandom;
      model_retire = model_retire + 32'd1;
      model_pc = npc;
      check("post_pc", pc_out, npc);
      check("post_retire", retire_cnt, model_retire);
      check("post_valid", {31'd0, inst_valid}, 32'd0);
      check("post_err", {31'd0, addr_err}, {31'd0, (npc[1:0] != 2'b00)});
      check("post_req", {31'd0, imem_req}, {31'd0, (npc[1:0] == 2'b00)});
   endtask

   initial begin
      logic [31:0] r;
      apply_reset();
      // Sequential stream, then a jump at 0x3008
      do_fetch(0, 0, 0, model_pc + 32'd4);
      do_fetch(0, 0, 0, model_pc + 32'd4);
      do_fetch(0, 0, 0, 32'h0000_4000);
      check("retire_after_3", retire_cnt, 32'd3);
      do_fetch(0, 0, 0, model_pc + 32'd4);
      // Backpressure and slow memory
      do_fetch(0, 0, 5, model_pc + 32'd4);
      do_fetch(4, 3, 0, model_pc + 32'd4);
      for (int k = 0; k < 40; k++) begin
         r = $urandom;
         r[1:0] = 2'b00;
         do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? r : model_pc + 32'd4);
      end
      // Misaligned target traps into ERR
      do_fetch(1, 1, 1, 32'h0000_4000);
      do_fetch(0, 0, 0, 32'h0000_4002);
      for (int i = 0; i < 6; i++) begin
         imem_gnt = 1'($urandom_range(0, 1));
         imem_rvalid = 1'($urandom_range(0, 1));
         inst_ready = 1'b1;
         npc_in = $urandom;
         step();
         check("err_noreq", {31'd0, imem_req}, 32'd0);
         check("err_novalid", {31'd0, inst_valid}, 32'd0);
         check("err_sticky", {31'd0, addr_err}, 32'd1);
         check("err_pc", pc_out, 32'h0000_4002);
         check("err_retire", retire_cnt, model_retire);
      end
      apply_reset();
      do_fetch(0, 1, 0, model_pc + 32'd4);
      do_fetch(2, 0, 1, model_pc + 32'd4);
      // Async reset between edges while in WAIT
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async_pc", pc_out, RST_PC);
      check("async_retire", retire_cnt, 32'd0);
      check("async_valid", {31'd0, inst_valid}, 32'd0);
      check("async_inst", inst_out, 32'd0);
      check("async_req", {31'd0, imem_req}, 32'd1);
      step();
      rst = 1'b0;
      exp_q.delete();
      model_pc = RST_PC;
      model_retire = 32'd0;
      do_fetch(0, 0, 0, model_pc + 32'd4);
      do_fetch(1, 2, 2, model_pc + 32'd4);
      do_fetch(0, 0, 0, model_pc + 32'd4);
      step();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
